// File: rtl/eth_phy_10g_pkg.sv
// Shared types and constants for the 10GBASE-R receive path.
// Holds lock FSM encodings and 64b/66b sync header values.
package eth_phy_10g_pkg;

  typedef enum logic [2:0] {
    ST_RST_ALIGN = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_HI_BER    = 3'd3
  } lock_state_e;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// Hi-BER monitor: counts invalid sync headers per fixed window.
// Flag sets mid-window at threshold and clears at a clean wrap.
module eth_phy_10g_rx_ber_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int BER_WINDOW = 19531,
  parameter int BER_THRESH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] hdr,
  output logic       hi_ber,
  output logic       window_end,
  output logic       window_hi_ber
);

  localparam int WW = $clog2(BER_WINDOW + 1);
  localparam int EW = $clog2(BER_THRESH + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(BER_WINDOW - 1);
  localparam logic [EW-1:0] ERR_MAX  = EW'(BER_THRESH);

  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] err_q, err_d, err_sum;
  logic          hi_q, hi_d;
  logic          err_hit, last;

  always_comb begin
    err_hit = enable && hdr_invalid(hdr);
    last    = enable && (win_q == WIN_LAST);
    err_sum = err_q;
    if (err_hit && (err_q != ERR_MAX)) begin
      err_sum = err_q + EW'(1);
    end
    win_d = win_q;
    err_d = err_sum;
    hi_d  = hi_q;
    if (clear) begin
      win_d = '0;
      err_d = '0;
      hi_d  = 1'b0;
    end else if (last) begin
      // last-cycle error already folded into err_sum
      win_d = '0;
      err_d = '0;
      hi_d  = (err_sum == ERR_MAX);
    end else begin
      if (enable) begin
        win_d = win_q + WW'(1);
      end
      if (err_sum == ERR_MAX) begin
        hi_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      err_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      err_q <= err_d;
      hi_q  <= hi_d;
    end
  end

  assign hi_ber        = hi_q;
  assign window_end    = last;
  assign window_hi_ber = last && (err_sum == ERR_MAX);

endmodule

// File: rtl/eth_phy_10g_rx_lock_ctrl.sv
// Receive lock controller: aligner reset, lock wait with retry,
// and hi-BER supervision driving link status and data qualifier.
module eth_phy_10g_rx_lock_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int BER_WINDOW   = 19531,
  parameter int BER_THRESH   = 16,
  parameter int HIBER_MAX    = 8
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_rx_block_lock,
  input  logic [1:0] i_serdes_rx_hdr,
  output logic       o_aligner_rst,
  output logic       o_rx_status,
  output logic       o_rx_high_ber,
  output logic       o_rx_valid,
  output logic [7:0] o_retry_count,
  output logic [2:0] o_state
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int HW = $clog2(HIBER_MAX + 1);

  lock_state_e   state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hib_cnt_q, hib_cnt_d;
  logic [7:0]    retry_q, retry_d;
  logic          aln_rst_q, status_q, valid_q;
  logic          retry_inc, active_q, active_d;
  logic          ber_en, ber_clear;
  logic          hi_ber, win_end, win_hi_ber;

  assign active_q = (state_q == ST_LOCKED) || (state_q == ST_HI_BER);
  assign active_d = (state_d == ST_LOCKED) || (state_d == ST_HI_BER);
  assign ber_en    = active_q && i_rx_block_lock;
  assign ber_clear = !active_d;

  eth_phy_10g_rx_ber_mon #(
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_mon (
    .clk           (clk),
    .rst_n         (i_rst_n),
    .enable        (ber_en),
    .clear         (ber_clear),
    .hdr           (i_serdes_rx_hdr),
    .hi_ber        (hi_ber),
    .window_end    (win_end),
    .window_hi_ber (win_hi_ber)
  );

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    timer_d   = '0;
    hib_cnt_d = '0;
    retry_inc = 1'b0;
    unique case (state_q)
      ST_RST_ALIGN: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (i_rx_block_lock) begin
          state_d = ST_LOCKED;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d   = ST_RST_ALIGN;
          retry_inc = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_LOCKED: begin
        if (!i_rx_block_lock) begin
          state_d = ST_WAIT_LOCK;
        end else if (hi_ber) begin
          state_d = ST_HI_BER;
        end
      end
      ST_HI_BER: begin
        hib_cnt_d = hib_cnt_q;
        if (!i_rx_block_lock) begin
          state_d = ST_WAIT_LOCK;
        end else if (win_end) begin
          if (!win_hi_ber) begin
            state_d = ST_LOCKED;
          end else if (hib_cnt_q == HW'(HIBER_MAX - 1)) begin
            state_d   = ST_RST_ALIGN;
            retry_inc = 1'b1;
          end else begin
            hib_cnt_d = hib_cnt_q + HW'(1);
          end
        end
      end
      default: state_d = ST_RST_ALIGN;
    endcase
    retry_d = retry_q;
    if (retry_inc && (retry_q != 8'hFF)) begin
      retry_d = retry_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RST_ALIGN;
      rst_cnt_q <= '0;
      timer_q   <= '0;
      hib_cnt_q <= '0;
      retry_q   <= '0;
      aln_rst_q <= 1'b1;
      status_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      timer_q   <= timer_d;
      hib_cnt_q <= hib_cnt_d;
      retry_q   <= retry_d;
      aln_rst_q <= (state_d == ST_RST_ALIGN);
      status_q  <= (state_q == ST_LOCKED) && !hi_ber
                   && i_rx_block_lock;
      valid_q   <= ber_en;
    end
  end

  assign o_aligner_rst = aln_rst_q;
  assign o_rx_status   = status_q;
  assign o_rx_high_ber = hi_ber;
  assign o_rx_valid    = valid_q;
  assign o_retry_count = retry_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_ctrl.sv
// Directed bench for the receive lock controller.
// Cycle numbers count clock periods since reset release.
module tb_eth_phy_10g_rx_lock_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rst_n_sat;
  logic       lock;
  logic [1:0] hdr;
  logic       o_aligner_rst, o_rx_status, o_rx_high_ber, o_rx_valid;
  logic [7:0] o_retry_count;
  logic [2:0] o_state;
  logic       s_aln, s_status, s_hiber, s_valid;
  logic [7:0] s_retry;
  logic [2:0] s_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  eth_phy_10g_rx_lock_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (200),
    .BER_WINDOW   (100),
    .BER_THRESH   (16),
    .HIBER_MAX    (2)
  ) dut (
    .clk             (clk),
    .i_rst_n         (rst_n),
    .i_rx_block_lock (lock),
    .i_serdes_rx_hdr (hdr),
    .o_aligner_rst   (o_aligner_rst),
    .o_rx_status     (o_rx_status),
    .o_rx_high_ber   (o_rx_high_ber),
    .o_rx_valid      (o_rx_valid),
    .o_retry_count   (o_retry_count),
    .o_state         (o_state)
  );

  eth_phy_10g_rx_lock_ctrl #(
    .RST_CYCLES   (1),
    .LOCK_TIMEOUT (2),
    .BER_WINDOW   (100),
    .BER_THRESH   (16),
    .HIBER_MAX    (2)
  ) dut_sat (
    .clk             (clk),
    .i_rst_n         (rst_n_sat),
    .i_rx_block_lock (1'b0),
    .i_serdes_rx_hdr (2'b01),
    .o_aligner_rst   (s_aln),
    .o_rx_status     (s_status),
    .o_rx_high_ber   (s_hiber),
    .o_rx_valid      (s_valid),
    .o_retry_count   (s_retry),
    .o_state         (s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_hdr(input int upto, input int lo,
                         input int hi, input int ex);
    while (cyc < upto) begin
      hdr = ((cyc >= lo && cyc <= hi) || cyc == ex) ? 2'b11 : 2'b01;
      @(posedge clk);
      #1;
      cyc++;
    end
    hdr = 2'b01;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    rst_n_sat = 1'b0;
    lock = 1'b0;
    hdr = 2'b01;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o_state !== 3'd0 || o_aligner_rst !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got st=%0d aln=%0b exp st=0 aln=1",
               o_state, o_aligner_rst);
    end
    checks++;
    if ({o_rx_status, o_rx_high_ber, o_rx_valid} !== 3'b000
        || o_retry_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_outs got sts/hb/vld=%b retry=%0d exp 000/0",
               {o_rx_status, o_rx_high_ber, o_rx_valid}, o_retry_count);
    end
  endtask

  task automatic test_retry_timeout();
    lock = 1'b0;
    apply_reset();
    run_hdr(203, -1, -1, -1);
    checks++;
    if (o_state !== 3'd1 || o_retry_count !== 8'd0) begin
      failures++;
      $display("FAIL to_c203 got st=%0d retry=%0d exp st=1 retry=0",
               o_state, o_retry_count);
    end
    run_hdr(204, -1, -1, -1);
    checks++;
    if (o_state !== 3'd0 || o_retry_count !== 8'd1
        || o_aligner_rst !== 1'b1) begin
      failures++;
      $display("FAIL to_c204 got st=%0d retry=%0d aln=%0b exp 0/1/1",
               o_state, o_retry_count, o_aligner_rst);
    end
    run_hdr(611, -1, -1, -1);
    checks++;
    if (o_retry_count !== 8'd2) begin
      failures++;
      $display("FAIL to_c611 got retry=%0d exp 2", o_retry_count);
    end
    run_hdr(612, -1, -1, -1);
    checks++;
    if (o_retry_count !== 8'd3 || o_state !== 3'd0) begin
      failures++;
      $display("FAIL to_c612 got retry=%0d st=%0d exp 3/0",
               o_retry_count, o_state);
    end
    run_hdr(815, -1, -1, -1);
    checks++;
    if (o_state !== 3'd1) begin
      failures++;
      $display("FAIL tie_pre got st=%0d exp 1", o_state);
    end
    lock = 1'b1;
    run_hdr(816, -1, -1, -1);
    checks++;
    if (o_state !== 3'd2 || o_retry_count !== 8'd3) begin
      failures++;
      $display("FAIL tie_lock_wins got st=%0d retry=%0d exp 2/3",
               o_state, o_retry_count);
    end
  endtask

  task automatic test_lock_acquire();
    bit bad;
    lock = 1'b0;
    apply_reset();
    bad = 1'b0;
    while (cyc < 4) begin
      if (o_aligner_rst !== 1'b1 || o_state !== 3'd0) bad = 1'b1;
      run_hdr(cyc + 1, -1, -1, -1);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL aln_pulse got low within c0-3 exp high");
    end
    checks++;
    if (o_aligner_rst !== 1'b0 || o_state !== 3'd1) begin
      failures++;
      $display("FAIL aln_c4 got aln=%0b st=%0d exp 0/1",
               o_aligner_rst, o_state);
    end
    run_hdr(50, -1, -1, -1);
    lock = 1'b1;
    run_hdr(51, -1, -1, -1);
    checks++;
    if (o_state !== 3'd2 || o_rx_status !== 1'b0) begin
      failures++;
      $display("FAIL lock_c51 got st=%0d sts=%0b exp 2/0",
               o_state, o_rx_status);
    end
    run_hdr(52, -1, -1, -1);
    checks++;
    if (o_rx_status !== 1'b1 || o_rx_valid !== 1'b1
        || o_retry_count !== 8'd0) begin
      failures++;
      $display("FAIL lock_c52 got sts=%0b vld=%0b retry=%0d exp 1/1/0",
               o_rx_status, o_rx_valid, o_retry_count);
    end
  endtask

  task automatic test_hi_ber_set_clear();
    run_hdr(176, 161, 176, -1);
    checks++;
    if (o_rx_high_ber !== 1'b0) begin
      failures++;
      $display("FAIL hb_c176 got %0b exp 0", o_rx_high_ber);
    end
    run_hdr(177, 161, 176, -1);
    checks++;
    if (o_rx_high_ber !== 1'b1 || o_rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL hb_c177 got hb=%0b vld=%0b exp 1/1",
               o_rx_high_ber, o_rx_valid);
    end
    run_hdr(178, -1, -1, -1);
    checks++;
    if (o_rx_status !== 1'b0 || o_state !== 3'd3
        || o_rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL hb_c178 got sts=%0b st=%0d vld=%0b exp 0/3/1",
               o_rx_status, o_state, o_rx_valid);
    end
    run_hdr(251, -1, -1, -1);
    checks++;
    if (o_rx_high_ber !== 1'b1 || o_state !== 3'd3) begin
      failures++;
      $display("FAIL hb_c251 got hb=%0b st=%0d exp 1/3",
               o_rx_high_ber, o_state);
    end
    run_hdr(350, -1, -1, -1);
    checks++;
    if (o_rx_high_ber !== 1'b1) begin
      failures++;
      $display("FAIL hb_c350 got %0b exp 1", o_rx_high_ber);
    end
    run_hdr(351, -1, -1, -1);
    checks++;
    if (o_rx_high_ber !== 1'b0 || o_state !== 3'd2) begin
      failures++;
      $display("FAIL hb_c351 got hb=%0b st=%0d exp 0/2",
               o_rx_high_ber, o_state);
    end
    run_hdr(352, -1, -1, -1);
    checks++;
    if (o_rx_status !== 1'b1 || o_rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL hb_c352 got sts=%0b vld=%0b exp 1/1",
               o_rx_status, o_rx_valid);
    end
  endtask

  task automatic test_below_thresh();
    bit seen;
    seen = 1'b0;
    while (cyc < 451) begin
      run_hdr(cyc + 1, 360, 373, 450);
      if (o_rx_high_ber !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || o_state !== 3'd2) begin
      failures++;
      $display("FAIL thr15 got seen=%0b st=%0d exp 0/2", seen, o_state);
    end
    run_hdr(550, 460, 474, 550);
    checks++;
    if (o_rx_high_ber !== 1'b0) begin
      failures++;
      $display("FAIL last_pre got %0b exp 0", o_rx_high_ber);
    end
    run_hdr(551, 460, 474, 550);
    checks++;
    if (o_rx_high_ber !== 1'b1 || o_state !== 3'd2) begin
      failures++;
      $display("FAIL last_cyc got hb=%0b st=%0d exp 1/2",
               o_rx_high_ber, o_state);
    end
    run_hdr(552, -1, -1, -1);
    checks++;
    if (o_state !== 3'd3) begin
      failures++;
      $display("FAIL last_st got %0d exp 3", o_state);
    end
  endtask

  task automatic test_hiber_realign();
    run_hdr(651, 560, 575, -1);
    checks++;
    if (o_state !== 3'd3) begin
      failures++;
      $display("FAIL hm_c651 got %0d exp 3", o_state);
    end
    run_hdr(750, 660, 675, -1);
    checks++;
    if (o_state !== 3'd3 || o_retry_count !== 8'd0) begin
      failures++;
      $display("FAIL hm_c750 got st=%0d retry=%0d exp 3/0",
               o_state, o_retry_count);
    end
    run_hdr(751, -1, -1, -1);
    checks++;
    if (o_state !== 3'd0 || o_retry_count !== 8'd1
        || o_aligner_rst !== 1'b1 || o_rx_high_ber !== 1'b0) begin
      failures++;
      $display("FAIL hm_c751 got st=%0d rt=%0d aln=%0b hb=%0b exp 0/1/1/0",
               o_state, o_retry_count, o_aligner_rst, o_rx_high_ber);
    end
    run_hdr(752, -1, -1, -1);
    checks++;
    if (o_rx_valid !== 1'b0 || o_rx_status !== 1'b0) begin
      failures++;
      $display("FAIL hm_c752 got vld=%0b sts=%0b exp 0/0",
               o_rx_valid, o_rx_status);
    end
    run_hdr(756, -1, -1, -1);
    checks++;
    if (o_state !== 3'd2) begin
      failures++;
      $display("FAIL relock_c756 got %0d exp 2", o_state);
    end
    run_hdr(783, 766, 781, -1);
    checks++;
    if (o_state !== 3'd3) begin
      failures++;
      $display("FAIL hb2_c783 got %0d exp 3", o_state);
    end
    run_hdr(955, 866, 881, -1);
    lock = 1'b0;
    run_hdr(956, -1, -1, -1);
    checks++;
    if (o_state !== 3'd1 || o_retry_count !== 8'd1
        || o_rx_high_ber !== 1'b0 || o_aligner_rst !== 1'b0) begin
      failures++;
      $display("FAIL drop_wend got st=%0d rt=%0d hb=%0b aln=%0b exp 1/1/0/0",
               o_state, o_retry_count, o_rx_high_ber, o_aligner_rst);
    end
  endtask

  task automatic test_async_reset();
    lock = 1'b1;
    run_hdr(990, 967, 982, -1);
    checks++;
    if (o_state !== 3'd3 || o_rx_high_ber !== 1'b1) begin
      failures++;
      $display("FAIL ar_pre got st=%0d hb=%0b exp 3/1",
               o_state, o_rx_high_ber);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (o_state !== 3'd0 || o_aligner_rst !== 1'b1
        || {o_rx_status, o_rx_high_ber, o_rx_valid} !== 3'b000
        || o_retry_count !== 8'd0) begin
      failures++;
      $display("FAIL ar_async got st=%0d aln=%0b shv=%b rt=%0d exp 0/1/000/0",
               o_state, o_aligner_rst,
               {o_rx_status, o_rx_high_ber, o_rx_valid}, o_retry_count);
    end
    #1 rst_n = 1'b1;
    cyc = 0;
    run_hdr(3, -1, -1, -1);
    checks++;
    if (o_state !== 3'd0 || o_aligner_rst !== 1'b1) begin
      failures++;
      $display("FAIL ar_c3 got st=%0d aln=%0b exp 0/1",
               o_state, o_aligner_rst);
    end
    run_hdr(5, -1, -1, -1);
    checks++;
    if (o_state !== 3'd2 || o_rx_high_ber !== 1'b0) begin
      failures++;
      $display("FAIL ar_c5 got st=%0d hb=%0b exp 2/0",
               o_state, o_rx_high_ber);
    end
    run_hdr(6, -1, -1, -1);
    checks++;
    if (o_rx_status !== 1'b1) begin
      failures++;
      $display("FAIL ar_c6 got sts=%0b exp 1", o_rx_status);
    end
  endtask

  task automatic test_retry_saturation();
    @(posedge clk);
    #2 rst_n_sat = 1'b1;
    cyc = 0;
    run_hdr(764, -1, -1, -1);
    checks++;
    if (s_retry !== 8'd254) begin
      failures++;
      $display("FAIL sat_c764 got %0d exp 254", s_retry);
    end
    run_hdr(765, -1, -1, -1);
    checks++;
    if (s_retry !== 8'd255) begin
      failures++;
      $display("FAIL sat_c765 got %0d exp 255", s_retry);
    end
    run_hdr(1000, -1, -1, -1);
    checks++;
    if (s_retry !== 8'd255) begin
      failures++;
      $display("FAIL sat_hold got %0d exp 255", s_retry);
    end
  endtask

  initial begin
    test_reset();
    test_retry_timeout();
    test_lock_acquire();
    test_hi_ber_set_clear();
    test_below_thresh();
    test_hiber_realign();
    test_async_reset();
    test_retry_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
